// File: rtl/axil_regbank_slave.sv
// AXI4-Lite slave register bank: NUM_REGS byte-strobed registers with per-register write pulses.
// Optional AXIL_REGBANK_WRCNT_EN adds a read-only OKAY-write counter at index NUM_REGS.
//
// state   | meaning
// WR_IDLE | collecting AW and W (independently held), commit when both present
// WR_RESP | write response pending, BVALID high until BREADY
// RD_IDLE | ARREADY high, waiting for an address
// RD_RESP | read data pending, RVALID high until RREADY
module axil_regbank_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                  ready_en;
  logic                  aw_held, w_held;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data, rd_mux;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_in_range, rd_ok;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

  // Readies stay low until the first clock after reset release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next       = wr_state;
    rd_next       = rd_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        S_AXI_AWREADY = ready_en && !aw_held;
        S_AXI_WREADY  = ready_en && !w_held;
        if (commit) wr_next = WR_RESP;
      end
      WR_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (b_hs) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
    case (rd_state)
      RD_IDLE: begin
        S_AXI_ARREADY = ready_en;
        if (ar_hs) rd_next = RD_RESP;
      end
      RD_RESP: begin
        S_AXI_RVALID = 1'b1;
        if (r_hs) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs    = S_AXI_BVALID && S_AXI_BREADY;
  assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs    = S_AXI_RVALID && S_AXI_RREADY;
  assign commit  = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  assign wr_idx      = aw_held ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
  assign wr_data     = w_held ? w_data_q : S_AXI_WDATA;
  assign wr_strb     = w_held ? w_strb_q : S_AXI_WSTRB;
  assign wr_in_range = int'(wr_idx) < NUM_REGS;
  assign rd_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:LSB];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
      wr_pulse <= '0;
      bresp_q  <= 2'b00;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        bresp_q <= wr_in_range ? 2'b00 : 2'b10;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (int'(wr_idx) == i) begin
            wr_pulse[i] <= 1'b1;
            for (int b = 0; b < STRB_W; b++)
              if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

`ifdef AXIL_REGBANK_WRCNT_EN
  logic [DATA_WIDTH-1:0] wr_cnt;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                  wr_cnt <= '0;
    else if (commit && wr_in_range) wr_cnt <= wr_cnt + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  end
`endif

  always_comb begin
    rd_mux = '0;
    rd_ok  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(rd_idx) == i) begin
        rd_mux = regs[i];
        rd_ok  = 1'b1;
      end
    end
`ifdef AXIL_REGBANK_WRCNT_EN
    if (int'(rd_idx) == NUM_REGS) begin
      rd_mux = wr_cnt;
      rd_ok  = 1'b1;
    end
`endif
  end

  // Read captures pre-write contents when a write commits on the same edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= 2'b00;
    end else if (ar_hs) begin
      rdata_q <= rd_mux;
      rresp_q <= rd_ok ? 2'b00 : 2'b10;
    end
  end

  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axil_regbank_slave.sv
// Self-checking bench for axil_regbank_slave (32-bit, 16 regs); scoreboard queues hold expected responses.
module tb_axil_regbank_slave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [511:0] reg_out;
  logic [15:0]  wr_pulse;

  axil_regbank_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .RESET_VALUE(32'h0)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_regs [16];
  int okay_writes = 0;
  int pulse_cnt [16];
  int snap [16];

  logic [1:0]  exp_bresp_q [$];
  logic [31:0] exp_rdata_q [$];
  logic [1:0]  exp_rresp_q [$];

  initial for (int i = 0; i < 16; i++) pulse_cnt[i] = 0;
  always @(negedge clk)
    for (int k = 0; k < 16; k++) if (wr_pulse[k] === 1'b1) pulse_cnt[k]++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] model_flat();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = model_regs[i];
    return f;
  endfunction

  function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                            input logic [3:0] strb);
    int idx;
    idx = int'(addr[7:2]);
    if (idx >= 16) return 2'b10;
    for (int b = 0; b < 4; b++) if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
    okay_writes++;
    return 2'b00;
  endfunction

  function automatic void model_read(input logic [7:0] addr, output logic [31:0] data,
                                     output logic [1:0] resp);
    int idx;
    idx = int'(addr[7:2]);
    data = 32'h0;
    resp = 2'b10;
    if (idx < 16) begin
      data = model_regs[idx];
      resp = 2'b00;
    end
`ifdef AXIL_REGBANK_WRCNT_EN
    if (idx == 16) begin
      data = okay_writes;
      resp = 2'b00;
    end
`endif
  endfunction

  task automatic drive_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int bready_delay, output logic [1:0] resp, output bit stable,
                             output bit timed_out);
    bit aw_done, w_done, aw_fire, w_fire;
    aw_done = 0; w_done = 0; stable = 1; timed_out = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_fire) begin awvalid = 0; aw_done = 1; end
      if (w_fire)  begin wvalid = 0;  w_done = 1;  end
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) timed_out = 1;
    for (int c = 0; c < 20 && !bvalid; c++) begin @(posedge clk); #1; end
    if (!bvalid) timed_out = 1;
    resp = bresp;
    for (int c = 0; c < bready_delay; c++) begin
      @(posedge clk); #1;
      if (bvalid !== 1'b1 || bresp !== resp) stable = 0;
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic drive_read(input logic [7:0] addr, input int rready_delay, output logic [31:0] data,
                            output logic [1:0] resp, output bit stable, output bit timed_out);
    bit done;
    done = 0; stable = 1; timed_out = 0;
    araddr = addr; arvalid = 1;
    for (int c = 0; c < 20 && !done; c++) begin
      done = arready;
      @(posedge clk); #1;
    end
    arvalid = 0;
    if (!done) timed_out = 1;
    for (int c = 0; c < 20 && !rvalid; c++) begin @(posedge clk); #1; end
    if (!rvalid) timed_out = 1;
    data = rdata; resp = rresp;
    for (int c = 0; c < rready_delay; c++) begin
      @(posedge clk); #1;
      if (rvalid !== 1'b1 || rdata !== data || rresp !== resp) stable = 0;
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got %b exp 00000", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if (rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00 || wr_pulse !== 16'h0) begin
      errors++; $display("FAIL reset_outputs got rdata %h bresp %b rresp %b pulse %h exp 0", rdata, bresp, rresp, wr_pulse);
    end
    checks++;
    if (reg_out !== model_flat()) begin errors++; $display("FAIL reset_regs got %h exp 0", reg_out); end
    @(negedge clk); #2 rst_n = 1; #1;
    checks++;
    if (awready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b exp 0", awready); end
    @(posedge clk); #1;
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL ready_after_edge got %b exp 111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [31:0] d; logic [1:0] rr; bit st, to;
    logic [31:0] ed; logic [1:0] er;
    snap = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_bresp_q.push_back(model_write(8'(i*4), 32'(i+1), 4'hF));
      drive_write(8'(i*4), 32'(i+1), 4'hF, 0, r, st, to);
      checks++;
      if (to || r !== exp_bresp_q.pop_front()) begin errors++; $display("FAIL basic_bresp reg %0d got %b timeout %0d exp 00", i, r, to); end
    end
    for (int i = 0; i < 4; i++) begin
      model_read(8'(i*4), ed, er);
      exp_rdata_q.push_back(ed); exp_rresp_q.push_back(er);
      drive_read(8'(i*4), 0, d, rr, st, to);
      ed = exp_rdata_q.pop_front(); er = exp_rresp_q.pop_front();
      checks++;
      if (to || d !== ed || rr !== er) begin errors++; $display("FAIL basic_read reg %0d got %h/%b exp %h/%b", i, d, rr, ed, er); end
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (pulse_cnt[i] - snap[i] !== ((i < 4) ? 1 : 0)) begin
        errors++; $display("FAIL basic_pulse reg %0d got %0d exp %0d", i, pulse_cnt[i] - snap[i], (i < 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [31:0] d; logic [1:0] rr; bit st, to;
    logic [31:0] ed; logic [1:0] er;
    exp_bresp_q.push_back(model_write(8'h08, 32'hAABBCCDD, 4'hF));
    drive_write(8'h08, 32'hAABBCCDD, 4'hF, 0, r, st, to);
    exp_bresp_q.push_back(model_write(8'h08, 32'h11223344, 4'b0011));
    drive_write(8'h08, 32'h11223344, 4'b0011, 0, rr, st, to);
    checks++;
    if (r !== exp_bresp_q.pop_front() || rr !== exp_bresp_q.pop_front())
      begin errors++; $display("FAIL strobe_bresp got %b %b exp 00 00", r, rr); end
    model_read(8'h08, ed, er);
    drive_read(8'h08, 0, d, rr, st, to);
    checks++;
    if (to || d !== ed || d !== 32'hAABB3344 || rr !== er) begin
      errors++; $display("FAIL strobe_read got %h/%b exp %h/%b", d, rr, ed, er);
    end
  endtask

  task automatic test_w_before_aw();
    snap = pulse_cnt;
    void'(model_write(8'h14, 32'hDEADBEEF, 4'hF));
    awaddr = 8'h14; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
    checks++;
    if (wready !== 1'b1) begin errors++; $display("FAIL wfirst_wready got %b exp 1", wready); end
    @(posedge clk); #1;
    wvalid = 0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (wready !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b1) begin
        errors++; $display("FAIL wfirst_hold got wready %b bvalid %b awready %b exp 0 0 1", wready, bvalid, awready);
      end
      @(posedge clk); #1;
    end
    awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || wr_pulse !== 16'h0020) begin
      errors++; $display("FAIL wfirst_commit got bvalid %b bresp %b pulse %h exp 1 00 0020", bvalid, bresp, wr_pulse);
    end
    bready = 1; @(posedge clk); #1; bready = 0;
    checks++;
    if (reg_out !== model_flat() || pulse_cnt[5] - snap[5] !== 1) begin
      errors++; $display("FAIL wfirst_single got pulses %0d exp 1", pulse_cnt[5] - snap[5]);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [31:0] d; bit st, to; int tot;
    logic [31:0] ed; logic [1:0] er;
    snap = pulse_cnt;
    exp_bresp_q.push_back(model_write(8'h40, 32'hFFFFFFFF, 4'hF));
    drive_write(8'h40, 32'hFFFFFFFF, 4'hF, 5, r, st, to);
    checks++;
    if (to || !st || r !== exp_bresp_q.pop_front() || r !== 2'b10) begin
      errors++; $display("FAIL oor_bresp got %b stable %0d exp 10 stable 1", r, st);
    end
    tot = 0;
    for (int i = 0; i < 16; i++) tot += pulse_cnt[i] - snap[i];
    checks++;
    if (reg_out !== model_flat() || tot !== 0) begin errors++; $display("FAIL oor_nochange got pulses %0d exp 0", tot); end
    model_read(8'h40, ed, er);
    exp_rdata_q.push_back(ed); exp_rresp_q.push_back(er);
    drive_read(8'h40, 5, d, r, st, to);
    ed = exp_rdata_q.pop_front(); er = exp_rresp_q.pop_front();
    checks++;
    if (to || !st || d !== ed || r !== er) begin
      errors++; $display("FAIL oor_read got %h/%b stable %0d exp %h/%b", d, r, st, ed, er);
    end
    model_read(8'hFC, ed, er);
    drive_read(8'hFC, 0, d, r, st, to);
    checks++;
    if (to || d !== ed || r !== 2'b10) begin errors++; $display("FAIL oor_top got %h/%b exp %h/10", d, r, ed); end
  endtask

  task automatic test_wstrb0();
    logic [1:0] r; bit st, to;
    snap = pulse_cnt;
    exp_bresp_q.push_back(model_write(8'h0C, 32'h55555555, 4'h0));
    drive_write(8'h0C, 32'h55555555, 4'h0, 0, r, st, to);
    checks++;
    if (to || r !== exp_bresp_q.pop_front() || reg_out !== model_flat() || pulse_cnt[3] - snap[3] !== 1) begin
      errors++; $display("FAIL wstrb0 got bresp %b pulses %0d exp 00 1", r, pulse_cnt[3] - snap[3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r; logic [31:0] d; bit st, to;
    logic [7:0] a; logic [31:0] v; logic [3:0] s;
    logic [31:0] ed; logic [1:0] er;
    for (int n = 0; n < 12; n++) begin
      a = 8'($urandom_range(0, 15) * 4); v = $urandom; s = 4'($urandom_range(0, 15));
      exp_bresp_q.push_back(model_write(a, v, s));
      drive_write(a, v, s, 0, r, st, to);
      checks++;
      if (to || r !== exp_bresp_q.pop_front()) begin errors++; $display("FAIL b2b_bresp addr %h got %b", a, r); end
    end
    for (int i = 0; i < 16; i++) begin
      model_read(8'(i*4), ed, er);
      exp_rdata_q.push_back(ed); exp_rresp_q.push_back(er);
    end
    for (int i = 0; i < 16; i++) begin
      drive_read(8'(i*4), 0, d, r, st, to);
      ed = exp_rdata_q.pop_front(); er = exp_rresp_q.pop_front();
      checks++;
      if (to || d !== ed || r !== er) begin errors++; $display("FAIL b2b_read reg %0d got %h/%b exp %h/%b", i, d, r, ed, er); end
    end
    checks++;
    if (reg_out !== model_flat()) begin errors++; $display("FAIL b2b_regout got %h exp %h", reg_out, model_flat()); end
  endtask

  task automatic test_rw_collision();
    logic [1:0] r; bit st, to; logic [31:0] old;
    void'(model_write(8'h1C, 32'h12345678, 4'hF));
    drive_write(8'h1C, 32'h12345678, 4'hF, 0, r, st, to);
    old = model_regs[7];
    void'(model_write(8'h1C, 32'hCAFEF00D, 4'hF));
    awaddr = 8'h1C; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 8'h1C;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    checks++;
    if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== old) begin
      errors++; $display("FAIL collision got rvalid %b bvalid %b rdata %h exp 1 1 %h", rvalid, bvalid, rdata, old);
    end
    bready = 1; rready = 1; @(posedge clk); #1; bready = 0; rready = 0;
    checks++;
    if (reg_out !== model_flat() || bvalid !== 1'b0 || rvalid !== 1'b0) begin
      errors++; $display("FAIL collision_after got reg7 %h exp %h", reg_out[7*32 +: 32], model_regs[7]);
    end
  endtask

  task automatic test_mid_reset();
    void'(model_write(8'h00, 32'h0000005A, 4'hF));
    awaddr = 8'h00; wdata = 32'h5A; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    checks++;
    if (bvalid !== 1'b1 || reg_out[31:0] !== model_regs[0]) begin
      errors++; $display("FAIL midrst_pre got bvalid %b reg0 %h exp 1 %h", bvalid, reg_out[31:0], model_regs[0]);
    end
    rst_n = 0; #1;
    for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;
    okay_writes = 0;
    checks++;
    if (bvalid !== 1'b0 || reg_out !== model_flat()) begin
      errors++; $display("FAIL midrst got bvalid %b reg0 %h exp 0 0", bvalid, reg_out[31:0]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || reg_out[31:0] !== 32'h0) begin
      errors++; $display("FAIL midrst_post got bvalid %b awready %b reg0 %h exp 0 1 0", bvalid, awready, reg_out[31:0]);
    end
  endtask

`ifdef AXIL_REGBANK_WRCNT_EN
  task automatic test_wrcnt();
    logic [1:0] r; logic [31:0] d; bit st, to;
    for (int i = 0; i < 3; i++) begin
      void'(model_write(8'(i*4), 32'(i+7), 4'hF));
      drive_write(8'(i*4), 32'(i+7), 4'hF, 0, r, st, to);
    end
    void'(model_write(8'h40, 32'h1, 4'hF));
    drive_write(8'h40, 32'h1, 4'hF, 0, r, st, to);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL wrcnt_write got %b exp 10", r); end
    drive_read(8'h40, 0, d, r, st, to);
    checks++;
    if (to || d !== 32'(okay_writes) || d !== 32'h3 || r !== 2'b00) begin
      errors++; $display("FAIL wrcnt_read got %h/%b exp 3/00", d, r);
    end
  endtask
`endif

  initial begin
    rst_n = 0;
    awaddr = 0; araddr = 0; awprot = 0; arprot = 0; wdata = 0; wstrb = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;
    test_reset();
    test_basic();
    test_strobe();
    test_w_before_aw();
    test_out_of_range();
    test_wstrb0();
    test_back_to_back();
    test_rw_collision();
    test_mid_reset();
`ifdef AXIL_REGBANK_WRCNT_EN
    test_wrcnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
